reg_dump_reader: RTL

- Sequential reader on one read port of the CPU register file; the write side is already in the design.
- Walks a contiguous window of registers and streams each (address, value) pair out on a valid/ready interface.
- Consumers: debug/trace logic and the simulation checker, so architectural state can be dumped without stalling writeback.
- Register-file read is combinational; this block supplies the address and registers the returned data.

---
 rtl/reg_dump_reader_pkg.sv | 17 +
 rtl/reg_dump_reader_if.sv | 33 +++
 rtl/reg_dump_reader.sv | 133 +++++++++++++
 3 files changed

// File: rtl/reg_dump_reader_pkg.sv
// Shared definitions for the register-file dump reader: default widths
// (kept in step with the CPU register file) and the FSM state encoding.
// Latency/backpressure: n/a (types and constants only).
package reg_dump_reader_pkg;

  // Defaults match the register file this block reads from.
  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage : reg_dump_reader_pkg

// File: rtl/reg_dump_reader_if.sv
// Output stream of (register index, register value) pairs with a last marker.
// Latency: none (wires only).
// Backpressure: plain valid/ready; a word moves when out_valid && out_ready.
// Ports: master drives out_valid/out_addr/out_data/out_last and samples
//        out_ready; slave is the mirror image.
interface reg_dump_reader_if #(
  parameter int DATA_WIDTH = reg_dump_reader_pkg::DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = reg_dump_reader_pkg::ADDR_WIDTH_DEF
);

  logic                  out_valid;
  logic                  out_ready;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;

  modport master (
    output out_valid,
    input  out_ready,
    output out_addr,
    output out_data,
    output out_last
  );

  modport slave (
    input  out_valid,
    output out_ready,
    input  out_addr,
    input  out_data,
    input  out_last
  );

endinterface : reg_dump_reader_if

// File: rtl/reg_dump_reader.sv
// Walks a window of register-file entries and streams (index, value) pairs.
// Latency: first word valid 2 cycles after start; at most one word per 2 cycles.
// Backpressure: a word is held stable until out_ready; abort drops it.
// Ports: clk, reset (async active-low), start/start_addr/count/abort control,
//        rf_addr/rf_data combinational read port, busy/done status, dump stream.
module reg_dump_reader
  import reg_dump_reader_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   count,
  input  logic                  abort,
  output logic [ADDR_WIDTH-1:0] rf_addr,
  input  logic [DATA_WIDTH-1:0] rf_data,
  output logic                  busy,
  output logic                  done,
  reg_dump_reader_if.master     dump
);

  localparam logic [ADDR_WIDTH:0]   REM_ONE  = (ADDR_WIDTH+1)'(1);
  // count==0 encodes a full sweep of 2**ADDR_WIDTH registers.
  localparam logic [ADDR_WIDTH:0]   REM_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH:0]   remaining_q;
  logic                  out_valid_q;
  logic [ADDR_WIDTH-1:0] out_addr_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic                  out_last_q;
  logic                  last_word;

  assign last_word = (remaining_q == REM_ONE);

  // addr_q only moves on the edge that enters READ, so driving the read port
  // straight from it keeps rf_addr steady through IDLE/HOLD/DONE.
  assign rf_addr = addr_q;

  assign dump.out_valid = out_valid_q;
  assign dump.out_addr  = out_addr_q;
  assign dump.out_data  = out_data_q;
  assign dump.out_last  = out_last_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b1;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        state_d = abort ? ST_IDLE : ST_HOLD;
      end
      ST_HOLD: begin
        // abort wins even when the consumer is accepting this cycle.
        if (abort) begin
          state_d = ST_IDLE;
        end else if (dump.out_ready) begin
          state_d = last_word ? ST_DONE : ST_READ;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q      <= '0;
      remaining_q <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            addr_q      <= start_addr;
            remaining_q <= (count == '0) ? REM_FULL : count;
          end
        end
        ST_READ: begin
          // Same-edge writeback to rf_addr is not forwarded: the pre-write
          // value is what gets captured.
          if (!abort) begin
            out_data_q  <= rf_data;
            out_addr_q  <= addr_q;
            out_last_q  <= last_word;
            out_valid_q <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (abort) begin
            out_valid_q <= 1'b0;
          end else if (dump.out_ready) begin
            out_valid_q <= 1'b0;
            if (!last_word) begin
              addr_q      <= addr_q + ADDR_ONE;
              remaining_q <= remaining_q - REM_ONE;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule : reg_dump_reader
